// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: FSM states,
// opcode constants, datapath select encodings and the opcode-class record
// produced by the instruction decoder.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    // Opcode field values of the supported instruction subset
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operation requested from the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format selection
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ALU operand A source
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B source
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus source
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Opcode classification; legal is set for any implemented opcode
    typedef struct packed {
        logic legal;
        logic is_load;
        logic is_store;
        logic is_rtype;
        logic is_itype;
        logic is_beq;
        logic is_jal;
    } op_class_t;

endpackage

// File: rtl/instrdec.sv
// Opcode decoder: classifies the opcode field and selects the immediate
// format. Purely combinational so ImmSrc follows op in every FSM state.
module instrdec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src,
    output op_class_t  op_class
);

    // Map opcode to immediate format and class flags
    always_comb begin
        imm_src  = IMM_I;
        op_class = 7'b0000000;
        case (op)
            OP_LOAD: begin
                imm_src          = IMM_I;
                op_class.legal   = 1'b1;
                op_class.is_load = 1'b1;
            end
            OP_STORE: begin
                imm_src           = IMM_S;
                op_class.legal    = 1'b1;
                op_class.is_store = 1'b1;
            end
            OP_RTYPE: begin
                imm_src           = IMM_I;
                op_class.legal    = 1'b1;
                op_class.is_rtype = 1'b1;
            end
            OP_ITYPE: begin
                imm_src           = IMM_I;
                op_class.legal    = 1'b1;
                op_class.is_itype = 1'b1;
            end
            OP_BRANCH: begin
                imm_src         = IMM_B;
                op_class.legal  = 1'b1;
                op_class.is_beq = 1'b1;
            end
            OP_JAL: begin
                imm_src         = IMM_J;
                op_class.legal  = 1'b1;
                op_class.is_jal = 1'b1;
            end
            default: begin
                imm_src  = IMM_I;
                op_class = 7'b0000000;
            end
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle control sequencer for the RV32I subset (lw, sw, R-type,
// I-type ALU, beq, jal). Sequences the shared ALU and memory port across
// instruction phases and stalls on mem_ready. Enables are gated by reset_n
// so nothing writes while reset is held; a reset mid-instruction restarts
// cleanly at FETCH.
module main_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal,
    output logic       retired
);

    state_t     state_r;
    state_t     next_state_s;
    logic       illegal_r;
    op_class_t  op_class_s;
    logic [1:0] imm_src_s;

    logic       adr_src_s;
    logic       ir_write_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] result_src_s;
    logic       pc_update_s;
    logic       branch_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       retire_s;

    instrdec u_instrdec (
        .op       (op),
        .imm_src  (imm_src_s),
        .op_class (op_class_s)
    );

    // State register; asynchronous reset returns to FETCH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sticky illegal flag, raised together with entry into TRAP
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_r <= 1'b0;
        end else if (next_state_s == TRAP) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Next-state and per-state datapath control decode
    always_comb begin
        next_state_s = state_r;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RS2;
        alu_op_s     = ALUOP_ADD;
        result_src_s = RES_ALUOUT;
        pc_update_s  = 1'b0;
        branch_s     = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        retire_s     = 1'b0;
        case (state_r)
            FETCH: begin
                // PC+4 is computed every cycle; IR and PC load only on ready
                alu_src_a_s  = SRCA_PC;
                alu_src_b_s  = SRCB_FOUR;
                alu_op_s     = ALUOP_ADD;
                result_src_s = RES_ALU;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_update_s  = 1'b1;
                    next_state_s = DECODE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: begin
                // Branch target OldPC + imm lands in ALUOut for BEQ
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_ADD;
                if (!op_class_s.legal) begin
                    next_state_s = TRAP;
                end else if (op_class_s.is_load || op_class_s.is_store) begin
                    next_state_s = MEMADR;
                end else if (op_class_s.is_rtype) begin
                    next_state_s = EXECR;
                end else if (op_class_s.is_itype) begin
                    next_state_s = EXECI;
                end else if (op_class_s.is_beq) begin
                    next_state_s = BEQ;
                end else if (op_class_s.is_jal) begin
                    next_state_s = JAL;
                end else begin
                    next_state_s = TRAP;
                end
            end
            MEMADR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_ADD;
                if (op_class_s.is_store) begin
                    next_state_s = MEMWRITE;
                end else begin
                    next_state_s = MEMREAD;
                end
            end
            MEMREAD: begin
                adr_src_s    = 1'b1;
                result_src_s = RES_ALUOUT;
                if (mem_ready) begin
                    next_state_s = MEMWB;
                end else begin
                    next_state_s = MEMREAD;
                end
            end
            MEMWB: begin
                result_src_s = RES_RDATA;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            MEMWRITE: begin
                // Write request stays up until memory accepts it
                adr_src_s    = 1'b1;
                result_src_s = RES_ALUOUT;
                mem_write_s  = 1'b1;
                if (mem_ready) begin
                    retire_s     = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = MEMWRITE;
                end
            end
            EXECR: begin
                alu_src_a_s  = SRCA_RS1;
                alu_src_b_s  = SRCB_RS2;
                alu_op_s     = ALUOP_FUNCT;
                next_state_s = ALUWB;
            end
            EXECI: begin
                alu_src_a_s  = SRCA_RS1;
                alu_src_b_s  = SRCB_IMM;
                alu_op_s     = ALUOP_FUNCT;
                next_state_s = ALUWB;
            end
            ALUWB: begin
                result_src_s = RES_ALUOUT;
                reg_write_s  = 1'b1;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            BEQ: begin
                // Compare rs1-rs2; PC loads the ALUOut target when zero
                alu_src_a_s  = SRCA_RS1;
                alu_src_b_s  = SRCB_RS2;
                alu_op_s     = ALUOP_SUB;
                result_src_s = RES_ALUOUT;
                branch_s     = 1'b1;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            JAL: begin
                // PC takes the target from ALUOut while OldPC+4 is formed
                alu_src_a_s  = SRCA_OLDPC;
                alu_src_b_s  = SRCB_FOUR;
                alu_op_s     = ALUOP_ADD;
                result_src_s = RES_ALUOUT;
                pc_update_s  = 1'b1;
                next_state_s = ALUWB;
            end
            TRAP: begin
                next_state_s = TRAP;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    assign AdrSrc    = adr_src_s;
    assign ALUSrcA   = alu_src_a_s;
    assign ALUSrcB   = alu_src_b_s;
    assign ALUOp     = alu_op_s;
    assign ResultSrc = result_src_s;
    assign ImmSrc    = imm_src_s;
    assign IRWrite   = reset_n & ir_write_s;
    assign PCWrite   = reset_n & (pc_update_s | (branch_s & zero));
    assign RegWrite  = reset_n & reg_write_s;
    assign MemWrite  = reset_n & mem_write_s;
    assign retired   = reset_n & retire_s;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: the stimulus process pushes the expected
// output vector for each cycle; a monitor on the falling edge pops and
// compares against the DUT outputs.
module tb_main_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal, retired;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;

    logic [16:0] act;
    logic [16:0] exp_q [$];
    string       tag_q [$];
    int          checks = 0;
    int          errors = 0;

    main_fsm dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    assign act = {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc,
                  PCWrite, RegWrite, MemWrite, illegal, retired};

    // Output vector layout:
    // {AdrSrc, IRWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc, PCWrite, RegWrite, MemWrite, illegal, retired}
    function automatic logic [16:0] v(input logic adr, input logic ir,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] aop, input logic [1:0] res,
                                      input logic [1:0] imm, input logic pcw,
                                      input logic rw, input logic mw,
                                      input logic ill, input logic ret);
        return {adr, ir, a, b, aop, res, imm, pcw, rw, mw, ill, ret};
    endfunction

    // FETCH: A=PC, B=4, add, result=ALU result; IR/PC load only when ready
    function automatic logic [16:0] fet(input logic [1:0] imm, input logic rdy);
        return v(1'b0, rdy, 2'b00, 2'b10, 2'b00, 2'b10, imm, rdy, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // DECODE: A=OldPC, B=imm, add
    function automatic logic [16:0] dec(input logic [1:0] imm);
        return v(1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // FETCH selects with every enable held off by reset
    function automatic logic [16:0] rstv(input logic [1:0] imm);
        return v(1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Monitor: compare each falling edge against the oldest expectation
    always @(negedge clk) begin
        logic [16:0] e;
        string       t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", t, act, e);
            end
        end
    end

    task automatic cyc(input string nm, input logic rn, input logic [6:0] o,
                       input logic z, input logic mr, input logic [16:0] e);
        reset_n   = rn;
        op        = o;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(e);
        tag_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        op        = LW;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with mem_ready=1: no IRWrite/PCWrite
        cyc("rst_a", 1'b0, LW, 1'b0, 1'b1, rstv(2'b00));
        cyc("rst_b", 1'b0, LW, 1'b0, 1'b1, rstv(2'b00));

        // lw, mem_ready=1: 5 cycles, retire in MEMWB
        cyc("lw_fetch",  1'b1, LW, 1'b0, 1'b1, fet(2'b00, 1'b1));
        cyc("lw_decode", 1'b1, LW, 1'b0, 1'b1, dec(2'b00));
        cyc("lw_memadr", 1'b1, LW, 1'b0, 1'b1, v(1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0));
        cyc("lw_memrd",  1'b1, LW, 1'b0, 1'b1, v(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0));
        cyc("lw_memwb",  1'b1, LW, 1'b0, 1'b1, v(1'b0,1'b0,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1));

        // sw: one FETCH wait, then MEMWRITE held 3 wait cycles
        cyc("sw_fetch_wait", 1'b1, SW, 1'b0, 1'b0, fet(2'b01, 1'b0));
        cyc("sw_fetch",      1'b1, SW, 1'b0, 1'b1, fet(2'b01, 1'b1));
        cyc("sw_decode",     1'b1, SW, 1'b0, 1'b1, dec(2'b01));
        cyc("sw_memadr",     1'b1, SW, 1'b0, 1'b1, v(1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0));
        for (int i = 0; i < 3; i++) begin
            cyc("sw_memwr_wait", 1'b1, SW, 1'b0, 1'b0, v(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b01,1'b0,1'b0,1'b1,1'b0,1'b0));
        end
        cyc("sw_memwr_done", 1'b1, SW, 1'b0, 1'b1, v(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b01,1'b0,1'b0,1'b1,1'b0,1'b1));

        // R-type with zero=1 throughout: zero must not leak into PCWrite
        cyc("r_fetch",  1'b1, RT, 1'b1, 1'b1, fet(2'b00, 1'b1));
        cyc("r_decode", 1'b1, RT, 1'b1, 1'b1, dec(2'b00));
        cyc("r_execr",  1'b1, RT, 1'b1, 1'b1, v(1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0));
        cyc("r_aluwb",  1'b1, RT, 1'b1, 1'b1, v(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1));

        // I-type ALU
        cyc("i_fetch",  1'b1, IT, 1'b0, 1'b1, fet(2'b00, 1'b1));
        cyc("i_decode", 1'b1, IT, 1'b0, 1'b1, dec(2'b00));
        cyc("i_execi",  1'b1, IT, 1'b0, 1'b1, v(1'b0,1'b0,2'b10,2'b01,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0));
        cyc("i_aluwb",  1'b1, IT, 1'b0, 1'b1, v(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1));

        // beq taken (zero=1) and not taken (zero=0), 3 cycles each
        cyc("beq1_fetch",  1'b1, BQ, 1'b0, 1'b1, fet(2'b10, 1'b1));
        cyc("beq1_decode", 1'b1, BQ, 1'b0, 1'b1, dec(2'b10));
        cyc("beq1_taken",  1'b1, BQ, 1'b1, 1'b1, v(1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,2'b10,1'b1,1'b0,1'b0,1'b0,1'b1));
        cyc("beq0_fetch",  1'b1, BQ, 1'b0, 1'b1, fet(2'b10, 1'b1));
        cyc("beq0_decode", 1'b1, BQ, 1'b1, 1'b1, dec(2'b10));
        cyc("beq0_nottkn", 1'b1, BQ, 1'b0, 1'b1, v(1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1));

        // jal: PCWrite in JAL, RegWrite in ALUWB, ImmSrc=11 throughout
        cyc("jal_fetch",  1'b1, JL, 1'b0, 1'b1, fet(2'b11, 1'b1));
        cyc("jal_decode", 1'b1, JL, 1'b0, 1'b1, dec(2'b11));
        cyc("jal_jal",    1'b1, JL, 1'b0, 1'b1, v(1'b0,1'b0,2'b01,2'b10,2'b00,2'b00,2'b11,1'b1,1'b0,1'b0,1'b0,1'b0));
        cyc("jal_aluwb",  1'b1, JL, 1'b0, 1'b1, v(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b11,1'b0,1'b1,1'b0,1'b0,1'b1));

        // lw with two MEMREAD wait cycles
        cyc("lw2_fetch",  1'b1, LW, 1'b0, 1'b1, fet(2'b00, 1'b1));
        cyc("lw2_decode", 1'b1, LW, 1'b0, 1'b1, dec(2'b00));
        cyc("lw2_memadr", 1'b1, LW, 1'b0, 1'b1, v(1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0));
        for (int i = 0; i < 2; i++) begin
            cyc("lw2_memrd_wait", 1'b1, LW, 1'b0, 1'b0, v(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0));
        end
        cyc("lw2_memrd", 1'b1, LW, 1'b0, 1'b1, v(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0));
        cyc("lw2_memwb", 1'b1, LW, 1'b0, 1'b1, v(1'b0,1'b0,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1));

        // Reset asserted while MEMWRITE waits: MemWrite drops at once
        cyc("swr_fetch",  1'b1, SW, 1'b0, 1'b1, fet(2'b01, 1'b1));
        cyc("swr_decode", 1'b1, SW, 1'b0, 1'b1, dec(2'b01));
        cyc("swr_memadr", 1'b1, SW, 1'b0, 1'b1, v(1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0));
        cyc("swr_memwr",  1'b1, SW, 1'b0, 1'b0, v(1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b01,1'b0,1'b0,1'b1,1'b0,1'b0));
        cyc("swr_reset",  1'b0, SW, 1'b0, 1'b0, rstv(2'b01));
        cyc("swr_reset2", 1'b0, SW, 1'b0, 1'b1, rstv(2'b01));
        cyc("swr_restart_wait", 1'b1, SW, 1'b0, 1'b0, fet(2'b01, 1'b0));
        cyc("swr_restart",      1'b1, IT, 1'b0, 1'b1, fet(2'b00, 1'b1));
        cyc("swr_i_decode",     1'b1, IT, 1'b0, 1'b1, dec(2'b00));

        // Finish that I-type, then an illegal opcode into TRAP
        cyc("swr_i_execi", 1'b1, IT, 1'b0, 1'b1, v(1'b0,1'b0,2'b10,2'b01,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0));
        cyc("swr_i_aluwb", 1'b1, IT, 1'b0, 1'b1, v(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1));
        cyc("bad_fetch",   1'b1, BAD, 1'b0, 1'b1, fet(2'b00, 1'b1));
        cyc("bad_decode",  1'b1, BAD, 1'b0, 1'b1, dec(2'b00));
        for (int i = 0; i < 20; i++) begin
            cyc("trap_hold", 1'b1, BAD, 1'b1, 1'b1, v(1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0));
        end
        cyc("trap_reset", 1'b0, BAD, 1'b0, 1'b1, rstv(2'b00));
        cyc("post_trap_fetch",  1'b1, BQ, 1'b0, 1'b1, fet(2'b10, 1'b1));
        cyc("post_trap_decode", 1'b1, BQ, 1'b0, 1'b1, dec(2'b10));

        // Every pushed expectation must have been consumed by the monitor
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
